score_ctrl: RTL and testbench

//  Game-session sequencer for the labyrinth score datapath. Runs the IDLE/PLAY/

---
 rtl/score_ctrl_if.sv | 29 ++
 rtl/score_ctrl.sv | 133 +++++++++++++
 tb/tb_score_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/score_ctrl_if.sv
// score_ctrl_if: control inputs and status outputs of the game-session sequencer.
//   start/pause/goal : player and maze controls (driven by the master)
//   state            : 0 IDLE, 1 PLAY, 2 PAUSE, 3 WIN, 4 LOSE
//   sec_tick         : one-cycle pulse with each score decrement
//   score_cnt        : live score
//   final_score      : score latched at game end
//   high_score       : best WIN score since reset
//   new_high         : last WIN beat the previous high score
interface score_ctrl_if;
  logic        start;
  logic        pause;
  logic        goal;
  logic [2:0]  state;
  logic        sec_tick;
  logic [15:0] score_cnt;
  logic [15:0] final_score;
  logic [15:0] high_score;
  logic        new_high;

  modport master (
    output start, pause, goal,
    input  state, sec_tick, score_cnt, final_score, high_score, new_high
  );

  modport slave (
    input  start, pause, goal,
    output state, sec_tick, score_cnt, final_score, high_score, new_high
  );
endinterface

// File: rtl/score_ctrl.sv
// score_ctrl: game-session sequencer for the labyrinth score datapath.
// Runs IDLE/PLAY/PAUSE/WIN/LOSE, charges one PENALTY per CLK_HZ cycles of
// play, latches the final score at game end and keeps the session high score.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - score_ctrl_if.slave (controls in, status out)
module score_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned PENALTY    = 65,
  parameter logic [15:0] SCORE_INIT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  score_ctrl_if.slave   bus
);

  localparam int unsigned      DIV_W    = $clog2(CLK_HZ);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [15:0]      PEN      = 16'(PENALTY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      score_q, score_d;
  logic [15:0]      final_q, final_d;
  logic [15:0]      high_q, high_d;
  logic             new_high_q, new_high_d;
  logic             sec_tick_q, sec_tick_d;

  logic             tick_due;
  logic [15:0]      score_sat;

  always_comb begin
    tick_due  = (state_q == S_PLAY) && (div_q == DIV_LAST);
    score_sat = (score_q < PEN) ? '0 : score_q - PEN;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      score_q    <= '0;
      final_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      score_q    <= score_d;
      final_q    <= final_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  // Next-state logic; in PLAY the priority is goal > timeout > pause
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_PLAY;
      S_PLAY: begin
        if (bus.goal)                         state_d = S_WIN;
        else if (tick_due && score_sat == '0) state_d = S_LOSE;
        else if (bus.pause)                   state_d = S_PAUSE;
      end
      S_PAUSE: if (bus.pause) state_d = S_PLAY;
      S_WIN,
      S_LOSE:  if (bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-output / datapath next values
  always_comb begin
    div_d      = div_q;
    score_d    = score_q;
    final_d    = final_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    sec_tick_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          div_d      = '0;
          score_d    = SCORE_INIT;
          new_high_d = 1'b0;
        end
      end
      S_PLAY: begin
        if (bus.goal) begin
          // A tick landing on the goal edge is dropped: final is the pre-tick score.
          div_d   = '0;
          final_d = score_q;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
        end else if (tick_due) begin
          // A tick wins over a same-cycle pause; a saturated zero ends the game.
          div_d      = '0;
          sec_tick_d = 1'b1;
          score_d    = score_sat;
          if (score_sat == '0) final_d = '0;
        end else if (!bus.pause) begin
          div_d = div_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  assign bus.state       = state_q;
  assign bus.sec_tick    = sec_tick_q;
  assign bus.score_cnt   = score_q;
  assign bus.final_score = final_q;
  assign bus.high_score  = high_q;
  assign bus.new_high    = new_high_q;

endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed bench for score_ctrl.
// dut1: CLK_HZ=4, PENALTY=65, SCORE_INIT=16'hFFFF
// dut2: CLK_HZ=4, PENALTY=100, SCORE_INIT=130 (saturation / LOSE path)
module tb_score_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   ticks1;
  int   base;

  score_ctrl_if bus1 ();
  score_ctrl_if bus2 ();

  score_ctrl #(.CLK_HZ(4), .PENALTY(65), .SCORE_INIT(16'hFFFF)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  score_ctrl #(.CLK_HZ(4), .PENALTY(100), .SCORE_INIT(16'd130)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts dut1 tick pulses; the pulse of the previous cycle is seen at each posedge.
  initial ticks1 = 0;
  always @(posedge clk) if (bus1.sec_tick === 1'b1) ticks1 = ticks1 + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (got === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start1();
    bus1.start = 1'b1; step(1); bus1.start = 1'b0;
  endtask

  task automatic pause1();
    bus1.pause = 1'b1; step(1); bus1.pause = 1'b0;
  endtask

  task automatic goal1();
    bus1.goal = 1'b1; step(1); bus1.goal = 1'b0;
  endtask

  task automatic start2();
    bus2.start = 1'b1; step(1); bus2.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus1.start = 1'b0; bus1.pause = 1'b0; bus1.goal = 1'b0;
    bus2.start = 1'b0; bus2.pause = 1'b0; bus2.goal = 1'b0;

    // Reset state
    step(2);
    chk("rst_state",    bus1.state,       0);
    chk("rst_score",    bus1.score_cnt,   0);
    chk("rst_final",    bus1.final_score, 0);
    chk("rst_high",     bus1.high_score,  0);
    chk("rst_tick",     bus1.sec_tick,    0);
    chk("rst_newhigh",  bus1.new_high,    0);
    chk("rst_state2",   bus2.state,       0);
    reset = 1'b0;
    step(1);

    // Ignored inputs in IDLE
    bus1.pause = 1'b1; bus1.goal = 1'b1; step(1);
    bus1.pause = 1'b0; bus1.goal = 1'b0;
    chk("idle_ignore", bus1.state, 0);

    // 10 ticks then goal
    start1();
    chk("g1_state_play", bus1.state,     1);
    chk("g1_score_init", bus1.score_cnt, 16'hFFFF);
    base = ticks1;
    step(40);
    chk("g1_score_10t",  bus1.score_cnt, 16'hFD75);
    chk("g1_still_play", bus1.state,     1);
    goal1();
    chk("g1_win",        bus1.state,       3);
    chk("g1_final",      bus1.final_score, 16'hFD75);
    chk("g1_high",       bus1.high_score,  16'hFD75);
    chk("g1_newhigh",    bus1.new_high,    1);
    chk("g1_tick_count", ticks1 - base,    10);
    step(5);
    chk("g1_win_hold",   bus1.state,       3);
    chk("g1_win_tick0",  bus1.sec_tick,    0);

    // WIN -> IDLE keeps scores; next start reloads
    start1();
    chk("g2_idle",        bus1.state,       0);
    chk("g2_idle_score",  bus1.score_cnt,   16'hFD75);
    chk("g2_idle_final",  bus1.final_score, 16'hFD75);
    chk("g2_idle_nh",     bus1.new_high,    1);
    start1();
    chk("g2_play",        bus1.state,       1);
    chk("g2_reload",      bus1.score_cnt,   16'hFFFF);
    chk("g2_nh_clear",    bus1.new_high,    0);
    step(80);
    goal1();
    chk("g2_win",         bus1.state,       3);
    chk("g2_final",       bus1.final_score, 16'hFAEB);
    chk("g2_high_kept",   bus1.high_score,  16'hFD75);
    chk("g2_newhigh0",    bus1.new_high,    0);

    // Replay equal to the high score
    start1();
    start1();
    step(40);
    goal1();
    chk("g3_final_eq",    bus1.final_score, 16'hFD75);
    chk("g3_high_eq",     bus1.high_score,  16'hFD75);
    chk("g3_newhigh_eq",  bus1.new_high,    0);

    // Pause mid-count: 3 ticks, 2 more counts, pause
    start1();
    start1();
    step(12);
    chk("g4_score_3t",    bus1.score_cnt, 16'hFF3C);
    chk("g4_tick3",       bus1.sec_tick,  1);
    step(2);
    pause1();
    chk("g4_paused",      bus1.state,     2);
    base = ticks1;
    step(100);
    chk("g4_pause_ticks", ticks1 - base,  0);
    chk("g4_pause_score", bus1.score_cnt, 16'hFF3C);
    chk("g4_pause_state", bus1.state,     2);
    pause1();
    chk("g4_resume",      bus1.state,     1);
    chk("g4_resume_tk",   bus1.sec_tick,  0);
    step(1);
    chk("g4_q1_tick",     bus1.sec_tick,  0);
    chk("g4_q1_score",    bus1.score_cnt, 16'hFF3C);
    step(1);
    chk("g4_q2_tick",     bus1.sec_tick,  1);
    chk("g4_q2_score",    bus1.score_cnt, 16'hFEFB);

    // start during PLAY ignored; goal+pause on the tick edge
    start1();
    chk("g5_start_ign",   bus1.state,     1);
    chk("g5_score_keep",  bus1.score_cnt, 16'hFEFB);
    step(2);
    bus1.goal = 1'b1; bus1.pause = 1'b1;
    step(1);
    bus1.goal = 1'b0; bus1.pause = 1'b0;
    chk("g5_win",         bus1.state,       3);
    chk("g5_final_pre",   bus1.final_score, 16'hFEFB);
    chk("g5_score_pre",   bus1.score_cnt,   16'hFEFB);
    chk("g5_no_tick",     bus1.sec_tick,    0);
    chk("g5_high",        bus1.high_score,  16'hFEFB);
    chk("g5_newhigh",     bus1.new_high,    1);

    // Asynchronous reset in the middle of a game
    start1();
    start1();
    step(3);
    #2 reset = 1'b1;
    #1;
    chk("ar_state",   bus1.state,       0);
    chk("ar_score",   bus1.score_cnt,   0);
    chk("ar_final",   bus1.final_score, 0);
    chk("ar_high",    bus1.high_score,  0);
    chk("ar_newhigh", bus1.new_high,    0);
    @(negedge clk);
    reset = 1'b0;
    step(1);

    // Saturating penalty -> LOSE (dut2)
    start2();
    chk("sat_play",    bus2.state,     1);
    chk("sat_init",    bus2.score_cnt, 130);
    step(4);
    chk("sat_t1",      bus2.score_cnt, 30);
    chk("sat_t1_tick", bus2.sec_tick,  1);
    chk("sat_t1_play", bus2.state,     1);
    step(4);
    chk("sat_lose",    bus2.state,       4);
    chk("sat_zero",    bus2.score_cnt,   0);
    chk("sat_final",   bus2.final_score, 0);
    chk("sat_high",    bus2.high_score,  0);
    chk("sat_t2_tick", bus2.sec_tick,    1);
    step(3);
    chk("sat_hold",    bus2.state,       4);
    chk("sat_tick0",   bus2.sec_tick,    0);
    start2();
    chk("sat_idle",    bus2.state,       0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
